// File: rtl/mfp_eic_sense_pkg.sv
// Shared definitions for the external interrupt controller: sense modes and
// request-vector/channel-number widths used by the sense stage and encoder.
package mfp_eic_sense_pkg;

    typedef enum logic [1:0] {
        EIC_MODE_OFF   = 2'b00,
        EIC_MODE_RISE  = 2'b01,
        EIC_MODE_FALL  = 2'b10,
        EIC_MODE_LEVEL = 2'b11
    } eic_mode_e;

    localparam int EIC_VECTOR_W = 256;
    localparam int EIC_NUM_W    = 8;

endpackage

// File: rtl/mfp_eic_sync.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset to 0.
module mfp_eic_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/mfp_eic_sense.sv
// EIC input stage: synchronise raw lines, apply per-channel sense mode, latch
// edge events into pending, and present pending & mask to the priority encoder.
module mfp_eic_sense
    import mfp_eic_sense_pkg::*;
#(
    parameter int EIC_CHANNELS = 64
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [EIC_CHANNELS-1:0]   signal,
    input  logic [2*EIC_CHANNELS-1:0] sense_mode,
    input  logic [EIC_CHANNELS-1:0]   mask,
    input  logic                      clr_we,
    input  logic [EIC_CHANNELS-1:0]   clr_data,
    input  logic                      ack_valid,
    input  logic [EIC_NUM_W-1:0]      ack_num,
    output logic [EIC_CHANNELS-1:0]   pending,
    output logic [EIC_VECTOR_W-1:0]   int_vector
);

    logic [EIC_CHANNELS-1:0] s2;
    logic [EIC_CHANNELS-1:0] s3_d, s3_q;
    logic [EIC_CHANNELS-1:0] pending_d, pending_q;

    mfp_eic_sync #(
        .WIDTH (EIC_CHANNELS)
    ) u_sync (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .d     (signal),
        .q     (s2)
    );

    // s3 follows s2 regardless of mode so a mode change sees no stale edge
    always_comb s3_d = s2;

    for (genvar i = 0; i < EIC_CHANNELS; i++) begin : g_ch
        localparam logic [EIC_NUM_W-1:0] CH_NUM = EIC_NUM_W'(i);

        eic_mode_e mode;
        logic      clr;
        logic      ch_d;

        assign mode = eic_mode_e'(sense_mode[2*i+1:2*i]);
        assign clr  = (clr_we & clr_data[i]) | (ack_valid & (ack_num == CH_NUM));

        // Set takes priority over clear so a coincident event is not lost
        always_comb begin
            ch_d = pending_q[i];
            case (mode)
                EIC_MODE_OFF:   ch_d = 1'b0;
                EIC_MODE_RISE:  ch_d = (s2[i] & ~s3_q[i]) | (pending_q[i] & ~clr);
                EIC_MODE_FALL:  ch_d = (~s2[i] & s3_q[i]) | (pending_q[i] & ~clr);
                EIC_MODE_LEVEL: ch_d = s2[i];
                default:        ch_d = 1'b0;
            endcase
        end

        assign pending_d[i] = ch_d;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s3_q      <= '0;
            pending_q <= '0;
        end else begin
            s3_q      <= s3_d;
            pending_q <= pending_d;
        end
    end

    assign pending    = pending_q;
    assign int_vector = EIC_VECTOR_W'(pending_q & mask);

endmodule

// File: tb/tb_mfp_eic_sense.sv
// Directed self-checking bench for mfp_eic_sense with 64 channels.
module tb_mfp_eic_sense;

    localparam int N = 64;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic [N-1:0]   signal;
    logic [2*N-1:0] sense_mode;
    logic [N-1:0]   mask;
    logic           clr_we;
    logic [N-1:0]   clr_data;
    logic           ack_valid;
    logic [7:0]     ack_num;
    logic [N-1:0]   pending;
    logic [255:0]   int_vector;

    int total = 0;
    int bad   = 0;

    mfp_eic_sense #(
        .EIC_CHANNELS (N)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .signal     (signal),
        .sense_mode (sense_mode),
        .mask       (mask),
        .clr_we     (clr_we),
        .clr_data   (clr_data),
        .ack_valid  (ack_valid),
        .ack_num    (ack_num),
        .pending    (pending),
        .int_vector (int_vector)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [N-1:0] sig;
        logic [1:0]   m7;
        logic [N-1:0] msk;
        logic         cw;
        logic [N-1:0] cd;
        logic         av;
        logic [7:0]   an;
        logic [N-1:0] exp_pend;
        logic [N-1:0] exp_int;
    } step_t;

    step_t tbl[$];

    localparam logic [N-1:0] MA  = 64'h8000_0000_0000_00A8;
    localparam logic [N-1:0] MB  = 64'h8000_0000_0000_00A9;
    localparam logic [N-1:0] B63 = 64'h8000_0000_0000_0000;

    task automatic add(input logic [N-1:0] sig, input logic [1:0] m7, input logic [N-1:0] msk,
                       input logic cw, input logic [N-1:0] cd, input logic av, input logic [7:0] an,
                       input logic [N-1:0] ep, input logic [N-1:0] ei);
        tbl.push_back('{sig, m7, msk, cw, cd, av, an, ep, ei});
    endtask

    task automatic check(input string name, input int step, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
        end
    endtask

    task automatic check_upper(input int step);
        logic [255:N] upper;
        upper = int_vector[255:N];
        total++;
        if (upper !== '0) begin
            bad++;
            $display("FAIL int_vector_upper step %0d: got %h want 0", step, upper);
        end
    endtask

    logic [2*N-1:0] base_mode;

    initial begin
        // ch0 FALL, ch3 RISE, ch5 RISE, ch63 LEVEL, ch7 driven per step, rest OFF
        base_mode          = '0;
        base_mode[1:0]     = 2'b10;
        base_mode[7:6]     = 2'b01;
        base_mode[11:10]   = 2'b01;
        base_mode[127:126] = 2'b11;

        HRESETn    = 1'b0;
        signal     = '1;
        sense_mode = '1;
        mask       = '1;
        clr_we     = 1'b0;
        clr_data   = '0;
        ack_valid  = 1'b0;
        ack_num    = '0;

        // Reset with all lines high in LEVEL mode
        repeat (2) @(posedge HCLK);
        #1;
        check("reset_pending", -1, pending, '0);
        check("reset_int", -1, int_vector[N-1:0], '0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check("rel_e1_pending", -1, pending, '0);
        @(posedge HCLK); #1;
        check("rel_e2_pending", -1, pending, '0);
        @(posedge HCLK); #1;
        check("rel_e3_pending", -1, pending, '1);
        check("rel_e3_int", -1, int_vector[N-1:0], '1);
        check_upper(-1);

        // Mid-operation reset discards everything immediately
        HRESETn = 1'b0;
        #1;
        check("midreset_pending", -1, pending, '0);

        signal     = 64'h1;
        sense_mode = base_mode;
        mask       = MA;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        repeat (4) @(posedge HCLK);
        #1;
        check("post_release_quiet", -1, pending, '0);

        // RISE ch5 with ack
        add(64'h21, 2'b00, MA, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h21, 2'b00, MA, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h21, 2'b00, MA, 0, 0, 0, 0,   64'h20, 64'h20);
        add(64'h01, 2'b00, MA, 0, 0, 0, 0,   64'h20, 64'h20);
        add(64'h01, 2'b00, MA, 0, 0, 0, 0,   64'h20, 64'h20);
        add(64'h01, 2'b00, MA, 0, 0, 1, 5,   64'h0,  64'h0);
        // FALL ch0 masked, then unmasked, then software clear
        add(64'h00, 2'b00, MA, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h00, 2'b00, MA, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h00, 2'b00, MA, 0, 0, 0, 0,   64'h1,  64'h0);
        add(64'h00, 2'b00, MB, 0, 0, 0, 0,   64'h1,  64'h1);
        add(64'h00, 2'b00, MB, 1, 64'h1, 0, 0, 64'h0, 64'h0);
        // RISE ch3: ack coincident with set, out-of-range ack, real ack
        add(64'h08, 2'b00, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h08, 2'b00, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h08, 2'b00, MB, 0, 0, 1, 3,   64'h8,  64'h8);
        add(64'h08, 2'b00, MB, 0, 0, 1, 200, 64'h8,  64'h8);
        add(64'h08, 2'b00, MB, 0, 0, 1, 3,   64'h0,  64'h0);
        // LEVEL ch63 ignores clear and ack
        add(B63 | 64'h08, 2'b00, MB, 0, 0, 0, 0, 64'h0, 64'h0);
        add(B63 | 64'h08, 2'b00, MB, 0, 0, 0, 0, 64'h0, 64'h0);
        add(B63 | 64'h08, 2'b00, MB, 0, 0, 0, 0, B63, B63);
        add(B63 | 64'h08, 2'b00, MB, 1, B63, 0, 0, B63, B63);
        add(B63 | 64'h08, 2'b00, MB, 0, 0, 1, 63, B63, B63);
        add(64'h08, 2'b00, MB, 0, 0, 0, 0,   B63,    B63);
        add(64'h08, 2'b00, MB, 0, 0, 0, 0,   B63,    B63);
        add(64'h08, 2'b00, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        // ch7: OFF with line high, switch to RISE, then real edge, then OFF
        add(64'h88, 2'b00, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h88, 2'b00, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h88, 2'b00, MB, 1, 64'h80, 0, 0, 64'h0, 64'h0);
        add(64'h88, 2'b01, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h88, 2'b01, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h08, 2'b01, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h08, 2'b01, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h08, 2'b01, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h88, 2'b01, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h88, 2'b01, MB, 0, 0, 0, 0,   64'h0,  64'h0);
        add(64'h88, 2'b01, MB, 1, 64'h80, 0, 0, 64'h80, 64'h80);
        add(64'h88, 2'b00, MB, 0, 0, 0, 0,   64'h0,  64'h0);

        // Each step: drive just after an edge, check just after the next edge
        for (int i = 0; i < tbl.size(); i++) begin
            signal              = tbl[i].sig;
            sense_mode          = base_mode;
            sense_mode[15:14]   = tbl[i].m7;
            mask                = tbl[i].msk;
            clr_we              = tbl[i].cw;
            clr_data            = tbl[i].cd;
            ack_valid           = tbl[i].av;
            ack_num             = tbl[i].an;
            @(posedge HCLK); #1;
            check("pending", i, pending, tbl[i].exp_pend);
            check("int_vector", i, int_vector[N-1:0], tbl[i].exp_int);
            check_upper(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
